jk_reg_bank: RTL and testbench
==============================

JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
- REQ-001: Parameter WIDTH, default 8; number of JK flip-flop channels; legal range 2..32.
- REQ-002: Parameter RST_VAL, default 0 (WIDTH bits); value loaded into q on reset.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: en  input  1  update enable; when 0, q holds except under sclr/load.
- REQ-006: sclr  input  1  synchronous clear to all-zero.
- REQ-007: load  input  1  synchronous parallel load of d.
- REQ-008: d  input  WIDTH  parallel load data.
- REQ-009: mode  input  2  operating mode: 00 JK, 01 count up, 10 count down, 11 shift left.
- REQ-010: j  input  WIDTH  per-channel J inputs, used in JK mode.
- REQ-011: k  input  WIDTH  per-channel K inputs, used in JK mode.
- REQ-012: sin  input  1  serial input, used in shift mode.
- REQ-013: q  output  WIDTH  registered flip-flop state.
- REQ-014: sout  output  1  serial output, equal to q[WIDTH-1] (combinational).
- REQ-015: wrap  output  1  registered one-cycle pulse on counter wrap.
- REQ-016: changed  output  1  registered one-cycle pulse when q changed at the previous edge.

Function
- REQ-017: Priority at each rising edge, highest first: sclr, load, en=0 hold, mode operation.
- REQ-018: sclr=1 sets q to 0 regardless of load, en, and mode.
- REQ-019: load=1 with sclr=0 sets q to d regardless of en and mode.
- REQ-020: JK mode: per bit i, {j[i],k[i]} 00 holds, 01 clears, 10 sets, 11 toggles; bits are independent.
- REQ-021: Count-up mode: each bit toggles when all lower bits are 1, and bit 0 always toggles, so q becomes (q+1) mod 2^WIDTH.
- REQ-022: Count-down mode: each bit toggles when all lower bits are 0, and bit 0 always toggles, so q becomes (q-1) mod 2^WIDTH.
- REQ-023: Shift mode: q becomes {q[WIDTH-2:0], sin}.
- REQ-024: wrap is 1 for exactly one cycle after an edge where a count operation took all-ones to 0 (up) or 0 to all-ones (down).
- REQ-025: wrap is never set by sclr, load, JK mode, or shift mode, even when the q transition matches a wrap pattern.
- REQ-026: changed is 1 for exactly one cycle after any edge where the new q differs from the old q, whatever the cause (sclr, load, or mode).
- REQ-027: Hold cycles (en=0, or JK 00 on all bits) leave q unchanged and drive changed to 0 and wrap to 0 on the next edge.
- REQ-028: A change of mode takes effect at the same edge; no internal state beyond q, wrap, and changed is kept.
- REQ-029: Continuous counting wraps indefinitely; wrap pulses once per full cycle of 2^WIDTH counts.

Reset
- REQ-030: rst=1 immediately forces q=RST_VAL, wrap=0, and changed=0, without waiting for a clock edge.
- REQ-031: While rst=1, clock edges have no effect; reset asserted mid-count discards the operation in progress.
- REQ-032: After rst deasserts, the first rising edge performs a normal update; changed is not asserted for the reset transition itself.

Verification (WIDTH=4, RST_VAL=0)
- REQ-033: JK mode, q=0000, j=1010, k=0000 for one edge, then j=1111, k=1111 for one edge -> q=1010 then q=0101; changed=1 after each edge.
- REQ-034: Count up from load d=1110, en=1, for 3 edges -> q=1111, 0000, 0001; wrap=1 only in the cycle after the 1111->0000 edge.
- REQ-035: Count down from q=0001 for 2 edges -> q=0000, 1111; wrap pulses once; then en=0 for 2 edges -> q holds 1111, changed=0.
- REQ-036: Shift mode, q=0000, sin sequence 1,0,1,1 -> q=0001, 0010, 0101, 1011; sout=1 after the 4th edge.
- REQ-037: sclr=1 and load=1 with d=1111 at the same edge -> q=0000; load alone with d=0000 from q=1111 in up mode -> q=0000 and wrap=0.
- REQ-038: rst pulsed between clock edges during up-count at q=0111 -> q=0000, wrap=0, and changed=0 with no clock edge; counting resumes from 0001 after release.

Source files
------------

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: bank of JK flip-flops with count-up, count-down and shift-left modes
module jk_reg_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             wrap,
  output logic             changed
);
  logic [WIDTH-1:0] q_q, q_d, op;
  logic             wrap_q, wrap_d, changed_q;
  always_comb begin
    op = mode == 2'b00 ? (j & ~q_q) | (~k & q_q) :
         mode == 2'b01 ? q_q + WIDTH'(1) :
         mode == 2'b10 ? q_q - WIDTH'(1) : {q_q[WIDTH-2:0], sin};
    q_d = sclr ? '0 : load ? d : !en ? q_q : op;
    // only a genuine count operation may flag a wrap
    wrap_d = !sclr && !load && en &&
             ((mode == 2'b01 && &q_q) || (mode == 2'b10 && ~|q_q));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_q       <= RST_VAL;
      wrap_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      wrap_q    <= wrap_d;
      changed_q <= q_d != q_q;
    end
  assign q       = q_q;
  assign sout    = q_q[WIDTH-1];
  assign wrap    = wrap_q;
  assign changed = changed_q;
endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank: scoreboard bench for jk_reg_bank at WIDTH=4, RST_VAL=0
module tb_jk_reg_bank;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, sclr = 1'b0, load = 1'b0, sin = 1'b0;
  logic [3:0] d = '0, j = '0, k = '0, q;
  logic [1:0] mode = '0;
  logic       sout, wrap, changed;
  typedef struct { logic [3:0] q; logic w; logic c; } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;

  jk_reg_bank #(.WIDTH(4), .RST_VAL(4'b0000)) dut (
    .clk(clk), .rst(rst), .en(en), .sclr(sclr), .load(load), .d(d), .mode(mode),
    .j(j), .k(k), .sin(sin), .q(q), .sout(sout), .wrap(wrap), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic e_i, s_i, l_i, input logic [3:0] d_i,
                        input logic [1:0] m_i, input logic [3:0] j_i, k_i, input logic si_i);
    en = e_i; sclr = s_i; load = l_i; d = d_i; mode = m_i; j = j_i; k = k_i; sin = si_i;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    n_chk++;
    if ({q, sout, wrap, changed} !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL reset: q=%b sout=%b wrap=%b changed=%b, expected 0000 0 0 0", q, sout, wrap, changed);
    end
    tick();
    n_chk++;
    if ({q, wrap, changed} !== 6'b0000_00) begin
      n_fail++;
      $display("FAIL reset_hold_edge: q=%b wrap=%b changed=%b, expected 0000 0 0", q, wrap, changed);
    end
    rst = 1'b0;
  endtask

  task automatic test_jk;
    logic [3:0] jt[5] = '{4'b1010, 4'b1111, 4'b0000, 4'b0000, 4'b1100};
    logic [3:0] kt[5] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b1100};
    logic [3:0] qt[5] = '{4'b1010, 4'b0101, 4'b0101, 4'b0000, 4'b1100};
    logic       ct[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, jt[i], kt[i], 1'b0);
      sb.push_back('{qt[i], 1'b0, ct[i]});
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({q, wrap, changed} !== {e.q, e.w, e.c}) begin
        n_fail++;
        $display("FAIL jk step %0d: q=%b wrap=%b changed=%b, expected q=%b wrap=%b changed=%b", i, q, wrap, changed, e.q, e.w, e.c);
      end
    end
  endtask

  task automatic test_count_up;
    logic [3:0] qt[4] = '{4'b1110, 4'b1111, 4'b0000, 4'b0001};
    logic       wt[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, i == 0, 4'b1110, 2'b01, 4'b0000, 4'b0000, 1'b0);
      sb.push_back('{qt[i], wt[i], 1'b1});
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({q, wrap, changed} !== {e.q, e.w, e.c}) begin
        n_fail++;
        $display("FAIL count_up step %0d: q=%b wrap=%b changed=%b, expected q=%b wrap=%b changed=%b", i, q, wrap, changed, e.q, e.w, e.c);
      end
    end
  endtask

  task automatic test_count_down_hold;
    logic [3:0] qt[4] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111};
    logic       wt[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       ct[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      set_in(i < 2, 1'b0, 1'b0, 4'b0000, 2'b10, 4'b0000, 4'b0000, 1'b0);
      sb.push_back('{qt[i], wt[i], ct[i]});
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({q, wrap, changed} !== {e.q, e.w, e.c}) begin
        n_fail++;
        $display("FAIL count_down step %0d: q=%b wrap=%b changed=%b, expected q=%b wrap=%b changed=%b", i, q, wrap, changed, e.q, e.w, e.c);
      end
    end
  endtask

  task automatic test_shift;
    logic       st[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] qt[5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b1011};
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, i == 0, 1'b0, 4'b0000, 2'b11, 4'b0000, 4'b0000, st[i]);
      sb.push_back('{qt[i], 1'b0, 1'b1});
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({q, wrap, changed} !== {e.q, e.w, e.c}) begin
        n_fail++;
        $display("FAIL shift step %0d: q=%b wrap=%b changed=%b, expected q=%b wrap=%b changed=%b", i, q, wrap, changed, e.q, e.w, e.c);
      end
    end
    n_chk++;
    if (sout !== 1'b1) begin
      n_fail++;
      $display("FAIL shift_sout: sout=%b, expected 1", sout);
    end
  endtask

  task automatic test_priority;
    logic       et[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       st[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       lt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] dt[7] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0101};
    logic [1:0] mt[7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    logic [3:0] qt[7] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0101};
    logic       ct[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin
        set_in(1'b1, 1'b0, 1'b1, 4'b1111, 2'b00, 4'b0000, 4'b0000, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 4'b0000, 4'b1111, 1'b0);
        tick();
      end
      set_in(et[i], st[i], lt[i], dt[i], mt[i], 4'b0000, 4'b1111, 1'b0);
      sb.push_back('{qt[i], 1'b0, ct[i]});
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({q, wrap, changed} !== {e.q, e.w, e.c}) begin
        n_fail++;
        $display("FAIL priority step %0d: q=%b wrap=%b changed=%b, expected q=%b wrap=%b changed=%b", i, q, wrap, changed, e.q, e.w, e.c);
      end
    end
  endtask

  task automatic test_reset_mid;
    set_in(1'b1, 1'b0, 1'b1, 4'b0111, 2'b01, 4'b0000, 4'b0000, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 4'b0000, 2'b01, 4'b0000, 4'b0000, 1'b0);
    n_chk++;
    if ({q, changed} !== 5'b0111_1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: q=%b changed=%b, expected 0111 1", q, changed);
    end
    #3 rst = 1'b1;
    #1;
    n_chk++;
    if ({q, wrap, changed} !== 6'b0000_00) begin
      n_fail++;
      $display("FAIL reset_mid_async: q=%b wrap=%b changed=%b, expected 0000 0 0", q, wrap, changed);
    end
    tick();
    n_chk++;
    if ({q, wrap, changed} !== 6'b0000_00) begin
      n_fail++;
      $display("FAIL reset_mid_held: q=%b wrap=%b changed=%b, expected 0000 0 0", q, wrap, changed);
    end
    #3 rst = 1'b0;
    sb.push_back('{4'b0001, 1'b0, 1'b1});
    tick();
    e = sb.pop_front();
    n_chk++;
    if ({q, wrap, changed} !== {e.q, e.w, e.c}) begin
      n_fail++;
      $display("FAIL reset_mid_resume: q=%b wrap=%b changed=%b, expected q=%b wrap=%b changed=%b", q, wrap, changed, e.q, e.w, e.c);
    end
  endtask

  task automatic test_back_to_back_wrap;
    logic [3:0] m = 4'b0001;
    int wraps = 0;
    set_in(1'b1, 1'b0, 1'b0, 4'b0000, 2'b01, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 32; i++) begin
      sb.push_back('{m + 4'd1, m == 4'b1111, 1'b1});
      m = m + 4'd1;
      tick();
      e = sb.pop_front();
      wraps += int'(wrap);
      n_chk++;
      if ({q, wrap, changed} !== {e.q, e.w, e.c}) begin
        n_fail++;
        $display("FAIL wrap_run step %0d: q=%b wrap=%b changed=%b, expected q=%b wrap=%b changed=%b", i, q, wrap, changed, e.q, e.w, e.c);
      end
    end
    n_chk++;
    if (wraps !== 2) begin
      n_fail++;
      $display("FAIL wrap_count: wraps=%0d, expected 2", wraps);
    end
  endtask

  initial begin
    test_reset();
    test_jk();
    test_count_up();
    test_count_down_hold();
    test_shift();
    test_priority();
    test_reset_mid();
    test_back_to_back_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
